// File: rtl/motor_pwm_driver.sv
// Motor PWM driver: free-running PWM counter, ramped duty per period, dead time on
// direction reversal, and a watchdog that forces a stop when commands stop arriving.
module motor_pwm_driver #(
    parameter int CNT_W           = 8,
    parameter int RAMP_STEP       = 16,
    parameter int DEAD_PERIODS    = 4,
    parameter int TIMEOUT_PERIODS = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_speed,
    input  logic             cmd_dir,
    output logic             PWM_Out,
    output logic             dir,
    output logic [CNT_W-1:0] duty,
    output logic             timeout
);

    localparam int WD_W   = $clog2(TIMEOUT_PERIODS + 1);
    localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);
    localparam logic [CNT_W-1:0]  STEP     = CNT_W'(RAMP_STEP);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_PERIODS - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

    typedef enum logic {
        ST_RUN,
        ST_DEAD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic [CNT_W-1:0]   tgt_speed_q, tgt_speed_d;
    logic               tgt_dir_q, tgt_dir_d;
    logic               dir_q, dir_d;
    logic               pwm_q, pwm_d;
    logic               timeout_q, timeout_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [DEAD_W-1:0]  dead_q, dead_d;
    logic               boundary;
    logic               accept;

    assign cmd_ready = (state_q == ST_RUN);
    assign PWM_Out   = pwm_q;
    assign dir       = dir_q;
    assign duty      = duty_q;
    assign timeout   = timeout_q;

    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        pwm_d       = (cnt_q < duty_q);
        state_d     = state_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        tgt_speed_d = tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;
        timeout_d   = timeout_q;
        wd_d        = wd_q;
        dead_d      = dead_q;
        boundary    = &cnt_q;
        accept      = cmd_valid && cmd_ready;

        // An accept on the expiry boundary wins over the watchdog.
        if (accept) begin
            tgt_speed_d = cmd_speed;
            tgt_dir_d   = cmd_dir;
            wd_d        = '0;
            timeout_d   = 1'b0;
        end else if (boundary && !timeout_q) begin
            if (wd_q == WD_LAST) begin
                timeout_d   = 1'b1;
                tgt_speed_d = '0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        if (boundary) begin
            unique case (state_q)
                ST_RUN: begin
                    if (tgt_dir_q == dir_q) begin
                        // Step only while the gap exceeds STEP, so the sum never wraps.
                        if (duty_q < tgt_speed_q) begin
                            duty_d = ((tgt_speed_q - duty_q) > STEP) ? duty_q + STEP : tgt_speed_q;
                        end else if (duty_q > tgt_speed_q) begin
                            duty_d = ((duty_q - tgt_speed_q) > STEP) ? duty_q - STEP : tgt_speed_q;
                        end
                    end else if (duty_q != '0) begin
                        duty_d = (duty_q > STEP) ? duty_q - STEP : '0;
                    end else begin
                        state_d = ST_DEAD;
                        dead_d  = '0;
                    end
                end
                ST_DEAD: begin
                    duty_d = '0;
                    if (dead_q == DEAD_LAST) begin
                        dir_d   = tgt_dir_q;
                        state_d = ST_RUN;
                        dead_d  = '0;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            duty_q      <= '0;
            dir_q       <= 1'b0;
            tgt_speed_q <= '0;
            tgt_dir_q   <= 1'b0;
            pwm_q       <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            dead_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            pwm_q       <= pwm_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
            dead_q      <= dead_d;
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver: vector table of per-period expectations plus
// hand-written watchdog and asynchronous-reset sequences.
module tb_motor_pwm_driver;

    localparam int PERIOD = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_speed = '0;
    logic       cmd_dir = 1'b0;
    logic       PWM_Out;
    logic       dir;
    logic [7:0] duty;
    logic       timeout;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string name;
        bit    do_cmd;
        int    speed;
        bit    cdir;
        int    exp_duty;
        bit    exp_dir;
        bit    exp_ready;
        bit    exp_to;
        int    n_periods;
        int    exp_high;
    } vec_t;

    vec_t vq[$];

    motor_pwm_driver #(
        .CNT_W(8),
        .RAMP_STEP(16),
        .DEAD_PERIODS(4),
        .TIMEOUT_PERIODS(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed),
        .cmd_dir(cmd_dir),
        .PWM_Out(PWM_Out),
        .dir(dir),
        .duty(duty),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Bench-side copy of the PWM counter position (edges since reset release).
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic to_boundary();
        do begin
            @(posedge clk);
            #1;
        end while (cyc % PERIOD != 0);
    endtask

    task automatic send(input int speed, input bit d);
        cmd_valid = 1'b1;
        cmd_speed = speed[7:0];
        cmd_dir   = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        repeat (PERIOD) begin
            @(posedge clk);
            #1;
            if (PWM_Out) hi++;
        end
    endtask

    task automatic add(input string name, input bit do_cmd, input int speed, input bit cdir,
                       input int exp_duty, input bit exp_dir, input bit exp_ready,
                       input int n_periods, input int exp_high);
        vec_t v;
        v.name = name; v.do_cmd = do_cmd; v.speed = speed; v.cdir = cdir;
        v.exp_duty = exp_duty; v.exp_dir = exp_dir; v.exp_ready = exp_ready;
        v.exp_to = 1'b0; v.n_periods = n_periods; v.exp_high = exp_high;
        vq.push_back(v);
    endtask

    initial begin
        int hi;

        // Idle at duty 0, then ramp-up to 64 and its duty cycle.
        add("idle",      0,   0, 0,   0, 0, 1, 3,   0);
        add("up16",      1,  64, 0,  16, 0, 1, 0,   0);
        add("up32",      0,   0, 0,  32, 0, 1, 0,   0);
        add("up48",      0,   0, 0,  48, 0, 1, 0,   0);
        add("up64",      0,   0, 0,  64, 0, 1, 1,  64);
        // Reversal: ramp down, dead time, flip, ramp up.
        add("rev48",     1,  64, 1,  48, 0, 1, 0,   0);
        add("rev32",     0,   0, 0,  32, 0, 1, 0,   0);
        add("rev16",     0,   0, 0,  16, 0, 1, 0,   0);
        add("rev0",      0,   0, 0,   0, 0, 1, 0,   0);
        add("dead1",     0,   0, 0,   0, 0, 0, 0,   0);
        add("dead2",     0,   0, 0,   0, 0, 0, 0,   0);
        add("dead3",     0,   0, 0,   0, 0, 0, 0,   0);
        add("dead4",     0,   0, 0,   0, 0, 0, 0,   0);
        add("flip",      0,   0, 0,   0, 1, 1, 0,   0);
        add("rup16",     0,   0, 0,  16, 1, 1, 0,   0);
        add("rup32",     0,   0, 0,  32, 1, 1, 0,   0);
        add("rup48",     0,   0, 0,  48, 1, 1, 0,   0);
        add("rup64",     0,   0, 0,  64, 1, 1, 0,   0);
        // Climb to 192, then land exactly on 200 and on 255.
        add("c80",       1, 192, 1,  80, 1, 1, 0,   0);
        add("c96",       0,   0, 0,  96, 1, 1, 0,   0);
        add("c112",      0,   0, 0, 112, 1, 1, 0,   0);
        add("c128",      0,   0, 0, 128, 1, 1, 0,   0);
        add("c144",      0,   0, 0, 144, 1, 1, 0,   0);
        add("c160",      0,   0, 0, 160, 1, 1, 0,   0);
        add("c176",      0,   0, 0, 176, 1, 1, 0,   0);
        add("c192",      0,   0, 0, 192, 1, 1, 0,   0);
        add("land200",   1, 200, 1, 200, 1, 1, 0,   0);
        add("m216",      1, 255, 1, 216, 1, 1, 0,   0);
        add("m232",      0,   0, 0, 232, 1, 1, 0,   0);
        add("m248",      0,   0, 0, 248, 1, 1, 0,   0);
        add("land255",   0,   0, 0, 255, 1, 1, 3, 255);
        // Reversal abandoned by a command restoring the current direction.
        add("ab239",     1, 255, 0, 239, 1, 1, 0,   0);
        add("ab223",     1, 100, 1, 223, 1, 1, 0,   0);
        add("d207",      0,   0, 0, 207, 1, 1, 0,   0);
        add("d191",      0,   0, 0, 191, 1, 1, 0,   0);
        add("d175",      0,   0, 0, 175, 1, 1, 0,   0);
        add("d159",      0,   0, 0, 159, 1, 1, 0,   0);
        add("d143",      0,   0, 0, 143, 1, 1, 0,   0);
        add("d127",      0,   0, 0, 127, 1, 1, 0,   0);
        add("d111",      0,   0, 0, 111, 1, 1, 0,   0);
        add("land100",   0,   0, 0, 100, 1, 1, 0,   0);

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm",   PWM_Out,   0);
        check("rst_duty",  duty,      0);
        check("rst_dir",   dir,       0);
        check("rst_to",    timeout,   0);
        check("rst_ready", cmd_ready, 1);
        #2 rst = 1'b0;

        foreach (vq[i]) begin
            if (vq[i].do_cmd) send(vq[i].speed, vq[i].cdir);
            to_boundary();
            check({vq[i].name, "_duty"},  duty,      vq[i].exp_duty);
            check({vq[i].name, "_dir"},   dir,       vq[i].exp_dir);
            check({vq[i].name, "_ready"}, cmd_ready, vq[i].exp_ready);
            check({vq[i].name, "_to"},    timeout,   vq[i].exp_to);
            for (int p = 0; p < vq[i].n_periods; p++) begin
                count_high(hi);
                check({vq[i].name, "_high"}, hi, vq[i].exp_high);
            end
        end

        // Watchdog: duty 64, then 200 silent periods.
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        send(64, 0);
        for (int b = 1; b <= 204; b++) begin
            to_boundary();
            if (b == 4)   check("wd_duty64", duty, 64);
            if (b == 199) check("wd_to199", timeout, 0);
            if (b == 200) begin
                check("wd_to200", timeout, 1);
                check("wd_hold64", duty, 64);
            end
            if (b == 201) check("wd_d48", duty, 48);
            if (b == 204) check("wd_d0", duty, 0);
        end
        send(32, 0);
        check("wd_clear", timeout, 0);
        to_boundary();
        check("wd_r16", duty, 16);
        to_boundary();
        check("wd_r32", duty, 32);
        check("wd_to_off", timeout, 0);

        // Asynchronous reset between clock edges while PWM_Out is high.
        repeat (5) @(posedge clk);
        #1;
        check("ar_pwm_pre", PWM_Out, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_pwm", PWM_Out, 0);
        check("ar_duty", duty, 0);
        check("ar_ready", cmd_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        send(16, 0);
        to_boundary();
        check("rs_duty", duty, 16);
        check("rs_dir", dir, 0);
        check("rs_to", timeout, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning PWM counter/duty width; period is 2^CNT_W clk cycles.
REQ-002 SHALL have parameter RAMP_STEP, default 16, meaning the maximum duty change per PWM period.
REQ-003 SHALL have parameter DEAD_PERIODS, default 4, meaning the full PWM periods held at duty 0 before a direction flip.
REQ-004 SHALL have parameter TIMEOUT_PERIODS, default 200, meaning the PWM periods without an accepted command before a forced stop.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port cmd_valid, input, 1 bit: the line-follow controller presents a speed command.
REQ-008 SHALL have port cmd_ready, output, 1 bit: the driver can accept a command.
REQ-009 SHALL have port cmd_speed, input, CNT_W bits: target duty.
REQ-010 SHALL have port cmd_dir, input, 1 bit: target direction, 0 = forward.
REQ-011 SHALL have port PWM_Out, output, 1 bit: registered motor PWM.
REQ-012 SHALL have port dir, output, 1 bit: registered motor direction.
REQ-013 SHALL have port duty, output, CNT_W bits: currently applied duty (status).
REQ-014 SHALL have port timeout, output, 1 bit: watchdog stop active.

Function
REQ-015 SHALL increment free-running counter cnt every clk, wrapping (2^CNT_W)-1 -> 0; the boundary is the edge where cnt wraps.
REQ-016 SHALL register PWM_Out = (cnt < duty) on each edge, giving one cycle of latency from cnt to PWM_Out.
REQ-017 SHALL update duty, dir and the state only on boundary edges, so a new duty first applies at cnt = 0.
REQ-018 SHALL accept a command on any edge where cmd_valid && cmd_ready, loading target_speed and target_dir and clearing the watchdog count and timeout.
REQ-019 SHALL assert cmd_ready in state RUN and deassert it in state DEAD.
REQ-020 SHALL, in RUN at a boundary with target_dir == dir, move duty toward target_speed by at most RAMP_STEP, landing exactly on target without overshoot or wrap.
REQ-021 SHALL, in RUN at a boundary with target_dir != dir and duty > 0, decrease duty by RAMP_STEP, saturating at 0.
REQ-022 SHALL, in RUN at a boundary with target_dir != dir and duty == 0, enter DEAD with the dead counter set to 0.
REQ-023 SHALL, in DEAD, hold duty 0 and count boundaries; at the DEAD_PERIODS-th boundary, load dir <= target_dir and return to RUN, with ramp-up starting at the next boundary.
REQ-024 SHALL abandon a reversal and ramp directly toward the new target, with no dead time, if a command received during ramp-down sets target_dir back to dir.
REQ-025 SHALL have the watchdog count boundaries since the last accepted command; on reaching TIMEOUT_PERIODS it sets timeout = 1 and target_speed = 0, and duty then ramps down per REQ-020.
REQ-026 SHALL, when an accept coincides with watchdog expiry, give priority to the accept: timeout stays 0 and the count restarts.
REQ-027 SHALL keep PWM_Out at 0 for the whole period when duty = 0, and low for exactly 1 cycle per period when duty = 2^CNT_W - 1.

Reset
REQ-028 SHALL, on rst = 1 and immediately (asynchronously), force cnt = 0, duty = 0, dir = 0, target_speed = 0, target_dir = 0, PWM_Out = 0, timeout = 0, state = RUN, cmd_ready = 1, and clear both the watchdog and dead counters.
REQ-029 SHALL restart cleanly from the reset state after rst is released mid-ramp or mid-DEAD, with no pending reversal retained.

Verification
REQ-030 SHALL cover: reset, then accept speed 64 dir 0 -> duty 16, 32, 48, 64 on successive boundaries, then PWM_Out high 64 of 256 cycles.
REQ-031 SHALL cover: duty 192, accept speed 200 -> duty 200 at the next boundary, not 208.
REQ-032 SHALL cover: steady state duty 64 dir 0, accept speed 64 dir 1 -> duty 48, 32, 16, 0; DEAD with cmd_ready = 0 for 4 periods; dir = 1; then duty 16, 32, 48, 64.
REQ-033 SHALL cover: duty 64 with no command for 200 periods -> timeout = 1 and duty ramps to 0; an accept of speed 32 -> timeout = 0 and duty reaches 32.
REQ-034 SHALL cover: rst asserted mid-period while PWM_Out = 1 -> PWM_Out = 0 and duty = 0 before the next clk edge.
REQ-035 SHALL cover: duty 0 -> PWM_Out never high over 3 periods; duty 255 -> exactly one low cycle per period.
